// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - assembles sync/addr/data[/chk] UART frames into register-write commands
// Optional checksum byte and CHK state enabled by defining UART_CMD_CHECKSUM_EN.
module uart_cmd_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CLOCKS = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic [7:0] cmd_addr_o,
  output logic [7:0] cmd_data_o,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i,
  output logic       err_o,
  output logic [1:0] err_code_o
);

  localparam int CW = $clog2(TIMEOUT_CLOCKS + 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CLOCKS);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CHK     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

`ifdef UART_CMD_CHECKSUM_EN
  typedef enum logic [1:0] {HUNT, ADDR, DATA, CHK} state_t;
`else
  typedef enum logic [1:0] {HUNT, ADDR, DATA} state_t;
`endif

  state_t        state_q, state_d;
  logic [7:0]    addr_sh_q, addr_sh_d;
  logic [7:0]    data_sh_q, data_sh_d;
  logic [7:0]    cmd_addr_q, cmd_addr_d;
  logic [7:0]    cmd_data_q, cmd_data_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          frame_done;
  logic          frame_ok;
  logic [7:0]    frame_data;

  always_comb begin
    state_d     = state_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = cmd_valid_q;
    err_d       = 1'b0;
    err_code_d  = ERR_NONE;
    cnt_d       = cnt_q;
    frame_done  = 1'b0;
    frame_ok    = 1'b1;
    frame_data  = data_sh_q;

    if (cmd_valid_q && cmd_ready_i) begin
      cmd_valid_d = 1'b0;
    end

    if (valid_i) begin
      case (state_q)
        HUNT: begin
          if (data_i == SYNC_BYTE) begin
            state_d = ADDR;
          end
        end
        ADDR: begin
          addr_sh_d = data_i;
          state_d   = DATA;
        end
        DATA: begin
          data_sh_d = data_i;
`ifdef UART_CMD_CHECKSUM_EN
          state_d   = CHK;
`else
          state_d    = HUNT;
          frame_done = 1'b1;
          frame_data = data_i;
`endif
        end
`ifdef UART_CMD_CHECKSUM_EN
        CHK: begin
          state_d    = HUNT;
          frame_done = 1'b1;
          frame_ok   = (data_i == (SYNC_BYTE ^ addr_sh_q ^ data_sh_q));
        end
`endif
        default: state_d = HUNT;
      endcase
      cnt_d = (state_d == HUNT) ? '0 : TIMEOUT_LOAD;
    end else if (state_q != HUNT) begin
      // A byte on the would-be expiry cycle takes the valid_i branch instead.
      if (cnt_q <= CW'(1)) begin
        state_d    = HUNT;
        cnt_d      = '0;
        err_d      = 1'b1;
        err_code_d = ERR_TIMEOUT;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    if (frame_done) begin
      if (!frame_ok) begin
        err_d      = 1'b1;
        err_code_d = ERR_CHK;
      end else if (!cmd_valid_q || cmd_ready_i) begin
        cmd_addr_d  = addr_sh_q;
        cmd_data_d  = frame_data;
        cmd_valid_d = 1'b1;
      end else begin
        err_d      = 1'b1;
        err_code_d = ERR_OVERRUN;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_addr_o  = cmd_addr_q;
  assign cmd_data_o  = cmd_data_q;
  assign cmd_valid_o = cmd_valid_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

endmodule
